// File: rtl/sdram_burst_splitter_if.sv
// Avalon-MM burst bus bundle: one instance per side of the splitter.
// Latency: none, plain wires.
// Backpressure: waitrequest from slave to master; readdatavalid is not backpressured.
// Ports (modport master drives the command/write side, slave drives the response side):
//   address, burstcount, read, write, writedata, byteenable : master -> slave
//   waitrequest, readdata, readdatavalid                     : slave -> master
interface sdram_burst_splitter_if #(
    parameter int ADDR_W = 25,
    parameter int BC_W   = 10,
    parameter int DATA_W = 16
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BC_W-1:0]   burstcount;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, burstcount, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, burstcount, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sdram_burst_splitter.sv
// Splits long upstream Avalon-MM bursts into page-bounded sub-bursts of at most BURST_MAX words.
// Latency: command issued one cycle after acceptance; read/write data pass through combinationally.
// Backpressure: upstream waitrequest follows the controller during write data; held high while reading.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-low reset
//   s_bus_io : upstream bus (slave side, burstcount up to BURST_IN_MAX)
//   m_bus_io : downstream bus towards the SDRAM controller (master side, burstcount up to BURST_MAX)
module sdram_burst_splitter #(
    parameter int WORD_WIDTH   = 1,
    parameter int COL_WIDTH    = 9,
    parameter int BANK_WIDTH   = 2,
    parameter int ROW_WIDTH    = 13,
    parameter int BURST_MAX    = 64,
    parameter int BURST_IN_MAX = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    sdram_burst_splitter_if.slave  s_bus_io,
    sdram_burst_splitter_if.master m_bus_io
);
    localparam int BYTE_AMOUNT = 1 << WORD_WIDTH;
    localparam int ADDR_WIDTH  = WORD_WIDTH + COL_WIDTH + BANK_WIDTH + ROW_WIDTH;
    localparam int IN_BC_W     = $clog2(BURST_IN_MAX) + 1;
    localparam int OUT_BC_W    = $clog2(BURST_MAX) + 1;
    localparam int PAGE_WORDS  = 1 << COL_WIDTH;
    // Wide enough for the remaining count and for a full page worth of words.
    localparam int CNT_W       = (IN_BC_W > COL_WIDTH + 1) ? IN_BC_W : COL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR_DATA
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
    logic [IN_BC_W-1:0]      remaining_q, remaining_d;
    logic [OUT_BC_W-1:0]     beat_q, beat_d;
    // Set for the first WR_DATA cycle of every chunk so the controller sees the
    // new address/burstcount before any data beat is offered.
    logic                    hold_q, hold_d;

    logic [COL_WIDTH-1:0]    cur_col;
    logic [CNT_W-1:0]        page_left;
    logic [CNT_W-1:0]        chunk_w;
    logic [OUT_BC_W-1:0]     chunk;
    logic [OUT_BC_W-1:0]     beat_inc;
    logic                    last_beat;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [IN_BC_W-1:0]      rem_next;

    // Sub-burst length: smallest of what is left, the controller limit and
    // the words left before the end of the current column page.
    assign cur_col   = cur_addr_q[WORD_WIDTH+COL_WIDTH-1:WORD_WIDTH];
    assign page_left = CNT_W'(PAGE_WORDS) - CNT_W'(cur_col);

    always_comb begin
        chunk_w = CNT_W'(remaining_q);
        if (CNT_W'(BURST_MAX) < chunk_w) begin
            chunk_w = CNT_W'(BURST_MAX);
        end
        if (page_left < chunk_w) begin
            chunk_w = page_left;
        end
    end

    assign chunk     = chunk_w[OUT_BC_W-1:0];
    assign beat_inc  = beat_q + OUT_BC_W'(1);
    assign last_beat = (beat_inc == chunk);
    assign addr_next = cur_addr_q + ADDR_WIDTH'(chunk) * ADDR_WIDTH'(BYTE_AMOUNT);
    assign rem_next  = remaining_q - IN_BC_W'(chunk);

    // Data paths are pure pass-through.
    assign m_bus_io.address    = cur_addr_q;
    assign m_bus_io.burstcount = chunk;
    assign m_bus_io.writedata  = s_bus_io.writedata;
    assign m_bus_io.byteenable = s_bus_io.byteenable;
    assign s_bus_io.readdata   = m_bus_io.readdata;

    always_comb begin
        state_d                = state_q;
        cur_addr_d             = cur_addr_q;
        remaining_d            = remaining_q;
        beat_d                 = beat_q;
        hold_d                 = hold_q;
        m_bus_io.read          = 1'b0;
        m_bus_io.write         = 1'b0;
        s_bus_io.readdatavalid = 1'b0;
        s_bus_io.waitrequest   = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (s_bus_io.read) begin
                    s_bus_io.waitrequest = 1'b0;
                    cur_addr_d           = s_bus_io.address;
                    remaining_d          = s_bus_io.burstcount;
                    beat_d               = '0;
                    if (s_bus_io.burstcount != '0) begin
                        state_d = RD_ISSUE;
                    end
                end else if (s_bus_io.write) begin
                    cur_addr_d  = s_bus_io.address;
                    remaining_d = s_bus_io.burstcount;
                    beat_d      = '0;
                    hold_d      = 1'b1;
                    if (s_bus_io.burstcount == '0) begin
                        // Empty write: swallow the command, nothing goes downstream.
                        s_bus_io.waitrequest = 1'b0;
                    end else begin
                        // First beat stays on the bus until WR_DATA takes it.
                        state_d = WR_DATA;
                    end
                end
            end

            RD_ISSUE: begin
                m_bus_io.read = 1'b1;
                if (!m_bus_io.waitrequest) begin
                    beat_d  = '0;
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                s_bus_io.readdatavalid = m_bus_io.readdatavalid;
                if (m_bus_io.readdatavalid) begin
                    beat_d = beat_inc;
                    if (last_beat) begin
                        cur_addr_d  = addr_next;
                        remaining_d = rem_next;
                        beat_d      = '0;
                        state_d     = (rem_next == '0) ? IDLE : RD_ISSUE;
                    end
                end
            end

            WR_DATA: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    m_bus_io.write       = s_bus_io.write;
                    s_bus_io.waitrequest = m_bus_io.waitrequest;
                    if (s_bus_io.write && !m_bus_io.waitrequest) begin
                        beat_d = beat_inc;
                        if (last_beat) begin
                            cur_addr_d  = addr_next;
                            remaining_d = rem_next;
                            beat_d      = '0;
                            hold_d      = 1'b1;
                            if (rem_next == '0) begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            hold_q      <= hold_d;
        end
    end
endmodule

// File: tb/tb_sdram_burst_splitter.sv
// Bench for sdram_burst_splitter: upstream master tasks, SDRAM controller model with
// random waitrequest and read-data gaps, and a reference memory plus sub-burst model.
module tb_sdram_burst_splitter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdram_burst_splitter_if #(.ADDR_W(25), .BC_W(10), .DATA_W(16)) s_bus ();
    sdram_burst_splitter_if #(.ADDR_W(25), .BC_W(7),  .DATA_W(16)) m_bus ();

    sdram_burst_splitter dut (
        .clk      (clk),
        .rst      (rst),
        .s_bus_io (s_bus),
        .m_bus_io (m_bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] cnt;
        logic        wr;
    } cmd_t;

    cmd_t        cmd_log[$];
    cmd_t        exp_cmds[$];
    logic [15:0] mem     [int unsigned];
    logic [15:0] ref_mem [int unsigned];
    int unsigned rd_pend[$];
    logic [15:0] rx_q[$];
    int          wr_left  = 0;
    int unsigned wr_waddr = 0;
    int          stray    = 0;
    bit          real_beat;
    int          n_vec    = 0;
    int          n_err    = 0;

    function automatic logic [15:0] init_word(input int unsigned wa);
        return 16'((wa * 32'd40503) ^ 32'h5A3C);
    endfunction

    function automatic logic [15:0] ctl_word(input int unsigned wa);
        if (mem.exists(wa)) return mem[wa];
        return init_word(wa);
    endfunction

    function automatic logic [15:0] ref_word(input int unsigned wa);
        if (ref_mem.exists(wa)) return ref_mem[wa];
        return init_word(wa);
    endfunction

    // Reference split: peel off min(left, 64, words to page end) until done.
    function automatic void split(input int unsigned addr, input int unsigned cnt, input bit wr);
        int unsigned a, r, c, col;
        a = addr;
        r = cnt;
        while (r > 0) begin
            col = (a / 2) % 512;
            c   = r;
            if (c > 64) c = 64;
            if (c > 512 - col) c = 512 - col;
            exp_cmds.push_back({a, c, wr});
            a = (a + 2 * c) % (1 << 25);
            r = r - c;
        end
    endfunction

    // SDRAM controller model: drives at negedge, observes handshakes 1ns later.
    always @(negedge clk) begin
        m_bus.waitrequest = ($urandom_range(0, 2) == 0);
        real_beat = 1'b0;
        if (stray > 0) begin
            m_bus.readdatavalid = 1'b1;
            m_bus.readdata      = 16'hDEAD;
            stray = stray - 1;
        end else if (rd_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
            m_bus.readdatavalid = 1'b1;
            m_bus.readdata      = ctl_word(rd_pend[0]);
            real_beat = 1'b1;
        end else begin
            m_bus.readdatavalid = 1'b0;
            m_bus.readdata      = 16'h0000;
        end
        #1;
        if (!rst) begin
            rd_pend.delete();
            wr_left = 0;
        end else begin
            if (real_beat) void'(rd_pend.pop_front());
            if (m_bus.read && !m_bus.waitrequest) begin
                cmd_log.push_back({32'(m_bus.address), 32'(m_bus.burstcount), 1'b0});
                for (int i = 0; i < int'(m_bus.burstcount); i++)
                    rd_pend.push_back(32'(m_bus.address) / 2 + i);
            end
            if (m_bus.write && !m_bus.waitrequest) begin
                logic [15:0] old;
                if (wr_left == 0) begin
                    cmd_log.push_back({32'(m_bus.address), 32'(m_bus.burstcount), 1'b1});
                    wr_left  = int'(m_bus.burstcount);
                    wr_waddr = 32'(m_bus.address) / 2;
                end
                old = ctl_word(wr_waddr);
                mem[wr_waddr] = {m_bus.byteenable[1] ? m_bus.writedata[15:8] : old[15:8],
                                 m_bus.byteenable[0] ? m_bus.writedata[7:0]  : old[7:0]};
                wr_waddr = wr_waddr + 1;
                wr_left  = wr_left - 1;
            end
        end
    end

    // Upstream read-data collector.
    always @(negedge clk) begin
        #1;
        if (rst && s_bus.readdatavalid === 1'b1) rx_q.push_back(s_bus.readdata);
    end

    task automatic start_cmd(input bit rd, input bit wr, input int unsigned addr,
                             input int unsigned cnt, input logic [15:0] d0, input logic [1:0] be0);
        @(negedge clk);
        s_bus.read       = rd;
        s_bus.write      = wr;
        s_bus.address    = 25'(addr);
        s_bus.burstcount = 10'(cnt);
        s_bus.writedata  = d0;
        s_bus.byteenable = be0;
    endtask

    task automatic wait_accept(output bit ok);
        int t;
        t = 0;
        #1;
        while (s_bus.waitrequest !== 1'b0 && t < 4000) begin
            @(negedge clk);
            #1;
            t++;
        end
        ok = (s_bus.waitrequest === 1'b0);
    endtask

    // Drives write beats; s_write is already high with beat 0 on the bus.
    task automatic write_beats(input int unsigned addr, input int cnt, input int be_beat,
                               input logic [15:0] base, output bit ok);
        int i, t;
        int unsigned wa;
        logic [15:0] old, wd;
        logic [1:0]  be;
        i = 0;
        t = 0;
        while (i < cnt && t < 6000) begin
            #1;
            if (s_bus.waitrequest === 1'b0) begin
                wa  = (addr / 2 + i) % (1 << 24);
                old = ref_word(wa);
                wd  = s_bus.writedata;
                be  = s_bus.byteenable;
                ref_mem[wa] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
                i++;
            end
            @(negedge clk);
            t++;
            if (i < cnt) begin
                s_bus.writedata  = base + 16'(i);
                s_bus.byteenable = (i == be_beat) ? 2'b01 : 2'b11;
            end else begin
                s_bus.write = 1'b0;
            end
        end
        s_bus.write = 1'b0;
        ok = (i == cnt);
    endtask

    task automatic run_read(input int unsigned addr, input int unsigned cnt, output bit ok);
        int t;
        start_cmd(1'b1, 1'b0, addr, cnt, 16'h0000, 2'b11);
        wait_accept(ok);
        @(negedge clk);
        s_bus.read = 1'b0;
        t = 0;
        while (rx_q.size() < int'(cnt) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        ok = ok && (rx_q.size() == int'(cnt));
    endtask

    task automatic run_write(input int unsigned addr, input int cnt, input logic [15:0] base,
                             input int be_beat, output bit ok);
        start_cmd(1'b0, 1'b1, addr, cnt, base, (be_beat == 0) ? 2'b01 : 2'b11);
        write_beats(addr, cnt, be_beat, base, ok);
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        exp_cmds.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_bus.read = 1'b0; s_bus.write = 1'b0; s_bus.address = '0; s_bus.burstcount = '0;
        s_bus.writedata = '0; s_bus.byteenable = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({m_bus.read, m_bus.write, s_bus.readdatavalid, s_bus.waitrequest} !== 4'b0001) begin
            n_err++;
            $display("FAIL reset outputs: got rd/wr/rdv/wait=%b want 0001",
                     {m_bus.read, m_bus.write, s_bus.readdatavalid, s_bus.waitrequest});
        end
        @(negedge clk);
        rst = 1'b1;
        clear_logs();
    endtask

    // Shared by the read tests: compares the logged commands and returned data.
    task automatic test_read(input string name, input int unsigned addr, input int unsigned cnt);
        bit ok;
        logic [15:0] exp_d[$];
        clear_logs();
        split(addr, cnt, 1'b0);
        for (int i = 0; i < int'(cnt); i++) exp_d.push_back(ref_word((addr / 2 + i) % (1 << 24)));
        run_read(addr, cnt, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s timeout: got %0d beats want %0d", name, rx_q.size(), cnt);
        end
        n_vec++;
        if (cmd_log.size() != exp_cmds.size()) begin
            n_err++;
            $display("FAIL %s cmd count: got %0d want %0d", name, cmd_log.size(), exp_cmds.size());
        end else begin
            foreach (exp_cmds[k]) begin
                n_vec++;
                if (cmd_log[k] !== exp_cmds[k]) begin
                    n_err++;
                    $display("FAIL %s cmd%0d: got addr=%h cnt=%0d wr=%b want addr=%h cnt=%0d wr=%b", name, k,
                             cmd_log[k].addr, cmd_log[k].cnt, cmd_log[k].wr,
                             exp_cmds[k].addr, exp_cmds[k].cnt, exp_cmds[k].wr);
                end
            end
        end
        foreach (exp_d[k]) begin
            if (k < rx_q.size()) begin
                n_vec++;
                if (rx_q[k] !== exp_d[k]) begin
                    n_err++;
                    $display("FAIL %s data%0d: got %h want %h", name, k, rx_q[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_write(input string name, input int unsigned addr, input int cnt,
                              input logic [15:0] base, input int be_beat);
        bit ok;
        int unsigned wa;
        clear_logs();
        split(addr, cnt, 1'b1);
        run_write(addr, cnt, base, be_beat, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s timeout: write did not complete", name);
        end
        n_vec++;
        if (cmd_log.size() != exp_cmds.size()) begin
            n_err++;
            $display("FAIL %s cmd count: got %0d want %0d", name, cmd_log.size(), exp_cmds.size());
        end else begin
            foreach (exp_cmds[k]) begin
                n_vec++;
                if (cmd_log[k] !== exp_cmds[k]) begin
                    n_err++;
                    $display("FAIL %s cmd%0d: got addr=%h cnt=%0d want addr=%h cnt=%0d", name, k,
                             cmd_log[k].addr, cmd_log[k].cnt, exp_cmds[k].addr, exp_cmds[k].cnt);
                end
            end
        end
        for (int i = 0; i < cnt; i++) begin
            wa = (addr / 2 + i) % (1 << 24);
            n_vec++;
            if (ctl_word(wa) !== ref_word(wa)) begin
                n_err++;
                $display("FAIL %s mem[%0d]: got %h want %h", name, wa, ctl_word(wa), ref_word(wa));
            end
        end
    endtask

    task automatic test_byteenable_mask();
        logic [15:0] got, init;
        got  = ctl_word(5);
        init = init_word(5);
        n_vec++;
        if (got !== {init[15:8], 8'h05}) begin
            n_err++;
            $display("FAIL be_mask beat5: got %h want %h", got, {init[15:8], 8'h05});
        end
    endtask

    task automatic test_zero_count();
        bit seen_cmd;
        clear_logs();
        for (int pass = 0; pass < 2; pass++) begin
            start_cmd(pass == 0, pass == 1, 32'h40, 0, 16'h1234, 2'b11);
            #1;
            n_vec++;
            if (s_bus.waitrequest !== 1'b0) begin
                n_err++;
                $display("FAIL zero_cnt accept%0d: got wait=%b want 0", pass, s_bus.waitrequest);
            end
            @(negedge clk);
            s_bus.read  = 1'b0;
            s_bus.write = 1'b0;
            seen_cmd = 1'b0;
            for (int c = 0; c < 4; c++) begin
                #1;
                if (s_bus.waitrequest !== 1'b1 || m_bus.read !== 1'b0 || m_bus.write !== 1'b0) seen_cmd = 1'b1;
                @(negedge clk);
            end
            n_vec++;
            if (seen_cmd || cmd_log.size() != 0) begin
                n_err++;
                $display("FAIL zero_cnt idle%0d: got activity=%b cmds=%0d want 0 0", pass, seen_cmd, cmd_log.size());
            end
        end
        test_read("zero_follow", 32'h40, 2);
    endtask

    task automatic test_reset_midburst();
        bit ok;
        int t;
        clear_logs();
        start_cmd(1'b1, 1'b0, 32'h800, 64, 16'h0, 2'b11);
        wait_accept(ok);
        @(negedge clk);
        s_bus.read = 1'b0;
        t = 0;
        while (rx_q.size() < 19 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (rx_q.size() < 19) begin
            n_err++;
            $display("FAIL rst_mid progress: got %0d beats want 19", rx_q.size());
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({m_bus.read, m_bus.write, s_bus.readdatavalid, s_bus.waitrequest} !== 4'b0001) begin
            n_err++;
            $display("FAIL rst_mid outputs: got rd/wr/rdv/wait=%b want 0001",
                     {m_bus.read, m_bus.write, s_bus.readdatavalid, s_bus.waitrequest});
        end
        rx_q.delete();
        stray = 3;
        repeat (5) @(negedge clk);
        n_vec++;
        if (rx_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_mid stray: got %0d beats passed up want 0", rx_q.size());
        end
        test_read("rst_after", 32'h200, 4);
    endtask

    task automatic test_read_write_same();
        bit ok1, ok2;
        logic [15:0] exp_d[$];
        int t;
        clear_logs();
        split(32'h1000, 4, 1'b0);
        split(32'h1000, 4, 1'b1);
        for (int i = 0; i < 4; i++) exp_d.push_back(ref_word(32'h800 + i));
        start_cmd(1'b1, 1'b1, 32'h1000, 4, 16'hC000, 2'b11);
        wait_accept(ok1);
        @(negedge clk);
        s_bus.read = 1'b0;
        write_beats(32'h1000, 4, -1, 16'hC000, ok2);
        t = 0;
        while (rx_q.size() < 4 && t < 100) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (!(ok1 && ok2)) begin
            n_err++;
            $display("FAIL rw_same timeout: got accept=%b write_done=%b want 1 1", ok1, ok2);
        end
        n_vec++;
        if (cmd_log.size() != exp_cmds.size()) begin
            n_err++;
            $display("FAIL rw_same cmd count: got %0d want %0d", cmd_log.size(), exp_cmds.size());
        end else begin
            foreach (exp_cmds[k]) begin
                n_vec++;
                if (cmd_log[k] !== exp_cmds[k]) begin
                    n_err++;
                    $display("FAIL rw_same cmd%0d: got addr=%h cnt=%0d wr=%b want addr=%h cnt=%0d wr=%b", k,
                             cmd_log[k].addr, cmd_log[k].cnt, cmd_log[k].wr,
                             exp_cmds[k].addr, exp_cmds[k].cnt, exp_cmds[k].wr);
                end
            end
        end
        n_vec++;
        if (rx_q.size() != 4) begin
            n_err++;
            $display("FAIL rw_same beats: got %0d want 4", rx_q.size());
        end else begin
            foreach (exp_d[k]) begin
                n_vec++;
                if (rx_q[k] !== exp_d[k]) begin
                    n_err++;
                    $display("FAIL rw_same data%0d: got %h want %h", k, rx_q[k], exp_d[k]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ctl_word(32'h800 + i) !== 16'hC000 + 16'(i)) begin
                n_err++;
                $display("FAIL rw_same mem%0d: got %h want %h", i, ctl_word(32'h800 + i), 16'hC000 + 16'(i));
            end
        end
    endtask

    task automatic test_random();
        int unsigned addr, cnt;
        for (int it = 0; it < 10; it++) begin
            if ($urandom_range(0, 1) == 1)
                addr = (($urandom_range(0, 63) * 512) + 512 - $urandom_range(1, 70)) * 2;
            else
                addr = $urandom_range(0, 32767) * 2;
            cnt = $urandom_range(1, 200);
            if ($urandom_range(0, 1) == 1)
                test_write("rand_wr", addr, int'(cnt), 16'($urandom), int'($urandom_range(0, cnt)));
            else
                test_read("rand_rd", addr, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_read("rd100", 32'h0000, 100);
        test_read("page_cross", 32'h03F0, 16);
        test_write("wr130", 32'h0000, 130, 16'h0000, 5);
        test_byteenable_mask();
        test_zero_count();
        test_reset_midburst();
        test_read_write_same();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_err);
        $fatal(1);
    end
endmodule
